// File: rtl/clock_div_prog.sv
// Programmable clock divider with square-wave or pulse output and a
// glitch-free divisor update that takes effect only at a period boundary.
module clock_div_prog #(
  parameter int WIDTH       = 16,
  parameter int DEFAULT_DIV = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             mode,
  input  logic             div_ld,
  input  logic [WIDTH-1:0] div_in,
  output logic             clk_out,
  output logic             tick,
  output logic             div_ack,
  output logic             pend,
  output logic [WIDTH-1:0] div_cur
);

  localparam logic [WIDTH-1:0] DEF_DIV = WIDTH'(DEFAULT_DIV);
  localparam logic [WIDTH-1:0] MIN_DIV = WIDTH'(2);
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] div_cur_q, div_cur_d;
  logic [WIDTH-1:0] pend_val_q, pend_val_d;
  logic             pend_q, pend_d;
  logic             ack_q, ack_d;
  logic             tick_q, tick_d;
  logic             clk_out_q, clk_out_d;

  logic [WIDTH-1:0] last_cnt;
  logic [WIDTH-1:0] half_n;
  logic [WIDTH-1:0] div_in_clamped;
  logic             wrap;
  logic             xfer;

  always_comb begin
    last_cnt       = div_cur_q - ONE;
    // >= rather than == so a corrupted counter can never run past N-1
    wrap           = en && (cnt_q >= last_cnt);
    xfer           = pend_q && (wrap || !en);
    div_in_clamped = (div_in < MIN_DIV) ? MIN_DIV : div_in;

    cnt_d      = cnt_q;
    div_cur_d  = div_cur_q;
    pend_val_d = pend_val_q;
    pend_d     = pend_q;
    ack_d      = 1'b0;

    if (en) begin
      cnt_d = wrap ? '0 : cnt_q + ONE;
    end

    if (xfer) begin
      div_cur_d = pend_val_q;
      pend_d    = 1'b0;
      ack_d     = 1'b1;
      cnt_d     = '0;
    end

    // A new load after the transfer logic: a coincident load stays pending
    if (div_ld) begin
      pend_val_d = div_in_clamped;
      pend_d     = 1'b1;
    end

    tick_d    = wrap;
    half_n    = (div_cur_d >> 1) + {{(WIDTH-1){1'b0}}, div_cur_d[0]};
    clk_out_d = mode ? tick_d : (cnt_d >= half_n);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      div_cur_q  <= DEF_DIV;
      pend_val_q <= '0;
      pend_q     <= 1'b0;
      ack_q      <= 1'b0;
      tick_q     <= 1'b0;
      clk_out_q  <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      div_cur_q  <= div_cur_d;
      pend_val_q <= pend_val_d;
      pend_q     <= pend_d;
      ack_q      <= ack_d;
      tick_q     <= tick_d;
      clk_out_q  <= clk_out_d;
    end
  end

  assign clk_out = clk_out_q;
  assign tick    = tick_q;
  assign div_ack = ack_q;
  assign pend    = pend_q;
  assign div_cur = div_cur_q;

endmodule

// File: tb/tb_clock_div_prog.sv
// Directed bench for clock_div_prog: a per-cycle vector table plus
// hand-written sequences for reset, clamping, reload races and pulse mode.
module tb_clock_div_prog;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic        mode;
  logic        div_ld;
  logic [15:0] div_in;
  logic        clk_out;
  logic        tick;
  logic        div_ack;
  logic        pend;
  logic [15:0] div_cur;

  int checks;
  int failures;

  clock_div_prog #(
    .WIDTH      (16),
    .DEFAULT_DIV(32)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (en),
    .mode   (mode),
    .div_ld (div_ld),
    .div_in (div_in),
    .clk_out(clk_out),
    .tick   (tick),
    .div_ack(div_ack),
    .pend   (pend),
    .div_cur(div_cur)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst_n;
    logic        en;
    logic        mode;
    logic        ld;
    logic [15:0] din;
    logic        exp_clk;
    logic        exp_tick;
    logic        exp_ack;
    logic        exp_pend;
    logic [15:0] exp_div;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic r, input logic e, input logic m,
                              input logic l, input logic [15:0] d,
                              input logic c, input logic t, input logic a,
                              input logic p, input logic [15:0] dv);
    vec_t x;
    x.rst_n = r; x.en = e; x.mode = m; x.ld = l; x.din = d;
    x.exp_clk = c; x.exp_tick = t; x.exp_ack = a; x.exp_pend = p; x.exp_div = dv;
    return x;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Apply inputs for one cycle; outputs are sampled 1 time unit after the edge.
  task automatic cyc(input logic r, input logic e, input logic m,
                     input logic l, input logic [15:0] d);
    rst_n = r; en = e; mode = m; div_ld = l; div_in = d;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic c, input logic t,
                         input logic a, input logic p, input logic [15:0] dv);
    chk({tag, ".clk_out"}, 32'(clk_out), 32'(c));
    chk({tag, ".tick"},    32'(tick),    32'(t));
    chk({tag, ".div_ack"}, 32'(div_ack), 32'(a));
    chk({tag, ".pend"},    32'(pend),    32'(p));
    chk({tag, ".div_cur"}, 32'(div_cur), 32'(dv));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int acks;
    checks = 0;
    failures = 0;
    rst_n = 1'b0; en = 1'b0; mode = 1'b0; div_ld = 1'b0; div_in = '0;

    // Table: load 5 while idle, run, reload 8 mid-period, stall 7 cycles, mode flips.
    vecs.push_back(mk(0,0,0,0,0,   0,0,0,0,32));
    vecs.push_back(mk(1,0,0,1,5,   0,0,0,1,32));
    vecs.push_back(mk(1,0,0,0,0,   0,0,1,0,5));
    vecs.push_back(mk(1,1,0,0,0,   0,0,0,0,5));
    vecs.push_back(mk(1,1,0,0,0,   0,0,0,0,5));
    vecs.push_back(mk(1,1,0,0,0,   1,0,0,0,5));
    vecs.push_back(mk(1,1,0,0,0,   1,0,0,0,5));
    vecs.push_back(mk(1,1,0,0,0,   0,1,0,0,5));
    vecs.push_back(mk(1,1,0,0,0,   0,0,0,0,5));
    vecs.push_back(mk(1,1,0,1,8,   0,0,0,1,5));
    vecs.push_back(mk(1,1,0,0,0,   1,0,0,1,5));
    vecs.push_back(mk(1,1,0,0,0,   1,0,0,1,5));
    vecs.push_back(mk(1,1,0,0,0,   0,1,1,0,8));
    vecs.push_back(mk(1,1,0,0,0,   0,0,0,0,8));
    vecs.push_back(mk(1,1,0,0,0,   0,0,0,0,8));
    vecs.push_back(mk(1,1,0,0,0,   0,0,0,0,8));
    vecs.push_back(mk(1,1,0,0,0,   1,0,0,0,8));
    vecs.push_back(mk(1,1,0,0,0,   1,0,0,0,8));
    for (int i = 0; i < 7; i++) vecs.push_back(mk(1,0,0,0,0, 1,0,0,0,8));
    vecs.push_back(mk(1,1,0,0,0,   1,0,0,0,8));
    vecs.push_back(mk(1,1,0,0,0,   1,0,0,0,8));
    vecs.push_back(mk(1,1,0,0,0,   0,1,0,0,8));
    vecs.push_back(mk(1,1,0,0,0,   0,0,0,0,8));
    vecs.push_back(mk(1,1,1,0,0,   0,0,0,0,8));
    vecs.push_back(mk(1,1,0,0,0,   0,0,0,0,8));
    vecs.push_back(mk(1,1,0,0,0,   1,0,0,0,8));
    vecs.push_back(mk(1,1,1,0,0,   0,0,0,0,8));
    vecs.push_back(mk(1,1,1,0,0,   0,0,0,0,8));
    vecs.push_back(mk(1,1,1,0,0,   0,0,0,0,8));
    vecs.push_back(mk(1,1,1,0,0,   1,1,0,0,8));
    vecs.push_back(mk(1,1,0,0,0,   0,0,0,0,8));

    foreach (vecs[i]) begin
      cyc(vecs[i].rst_n, vecs[i].en, vecs[i].mode, vecs[i].ld, vecs[i].din);
      chk_all($sformatf("vec%0d", i), vecs[i].exp_clk, vecs[i].exp_tick,
              vecs[i].exp_ack, vecs[i].exp_pend, vecs[i].exp_div);
      $display("vec %0d: clk_out=%0b tick=%0b ack=%0b pend=%0b div_cur=%0d",
               i, clk_out, tick, div_ack, pend, div_cur);
    end

    // Default divisor after reset: 16 low, 16 high, tick 32 cycles after release.
    cyc(0,0,0,0,0);
    chk_all("rst_default", 0, 0, 0, 0, 32);
    for (int k = 1; k <= 64; k++) begin
      cyc(1,1,0,0,0);
      chk($sformatf("def_clk%0d", k),  32'(clk_out), 32'((k % 32) >= 16));
      chk($sformatf("def_tick%0d", k), 32'(tick),    32'((k % 32) == 0));
    end
    $display("seq default: done at div_cur=%0d", div_cur);

    // Clamp: 0 and 1 both become 2; output toggles every cycle.
    cyc(0,0,0,0,0);
    cyc(1,0,0,1,0);
    chk("clamp0_pend", 32'(pend), 32'd1);
    cyc(1,0,0,0,0);
    chk_all("clamp0_xfer", 0, 0, 1, 0, 2);
    for (int k = 1; k <= 6; k++) begin
      cyc(1,1,0,0,0);
      chk($sformatf("n2_clk%0d", k),  32'(clk_out), 32'(k % 2));
      chk($sformatf("n2_tick%0d", k), 32'(tick),    32'((k % 2) == 0));
    end
    cyc(1,1,0,1,1);
    chk_all("clamp1_ld", 1, 0, 0, 1, 2);
    cyc(1,1,0,0,0);
    chk_all("clamp1_xfer", 0, 1, 1, 0, 2);
    $display("seq clamp: div_cur=%0d", div_cur);

    // Two loads before wrap give a single ack; a load on the transfer edge stays pending.
    cyc(0,0,0,0,0);
    for (int k = 0; k < 3; k++) cyc(1,1,0,0,0);
    cyc(1,1,0,1,9);
    chk("dbl_pend_a", 32'(pend), 32'd1);
    cyc(1,1,0,1,12);
    chk("dbl_pend_b", 32'(pend), 32'd1);
    chk("dbl_div_hold", 32'(div_cur), 32'd32);
    acks = 0;
    for (int k = 0; k < 27; k++) begin
      cyc(1,1,0,0,0);
      if (div_ack === 1'b1) acks++;
    end
    chk("dbl_ack_count", 32'(acks), 32'd1);
    chk_all("dbl_xfer", 0, 1, 1, 0, 12);
    cyc(1,1,0,1,7);
    for (int k = 0; k < 10; k++) cyc(1,1,0,0,0);
    chk_all("race_pre", 1, 0, 0, 1, 12);
    cyc(1,1,0,1,10);
    chk_all("race_xfer", 0, 1, 1, 1, 7);
    for (int k = 0; k < 6; k++) cyc(1,1,0,0,0);
    chk_all("race_wait", 1, 0, 0, 1, 7);
    cyc(1,1,0,0,0);
    chk_all("race_final", 0, 1, 1, 0, 10);
    $display("seq reload: div_cur=%0d", div_cur);

    // Pulse mode at N=4, load in the wrap cycle, then a mid-period reset.
    cyc(0,0,0,0,0);
    cyc(1,0,0,1,4);
    cyc(1,0,0,0,0);
    chk_all("p4_xfer", 0, 0, 1, 0, 4);
    for (int k = 1; k <= 12; k++) begin
      cyc(1,1,1,0,0);
      chk($sformatf("p4_clk%0d", k),  32'(clk_out), 32'((k % 4) == 0));
      chk($sformatf("p4_tick%0d", k), 32'(tick),    32'((k % 4) == 0));
    end
    for (int k = 0; k < 3; k++) cyc(1,1,0,0,0);
    cyc(1,1,0,1,6);
    chk_all("wrapld_edge", 0, 1, 0, 1, 4);
    for (int k = 0; k < 3; k++) cyc(1,1,0,0,0);
    chk_all("wrapld_wait", 1, 0, 0, 1, 4);
    cyc(1,1,0,0,0);
    chk_all("wrapld_xfer", 0, 1, 1, 0, 6);
    cyc(1,1,0,0,0);
    cyc(1,1,0,0,0);
    cyc(1,1,0,1,9);
    chk_all("mid_pre", 1, 0, 0, 1, 6);
    cyc(0,1,1,1,11);
    chk_all("mid_rst", 0, 0, 0, 0, 32);
    cyc(1,0,0,0,0);
    chk_all("mid_after", 0, 0, 0, 0, 32);
    $display("seq pulse/reset: div_cur=%0d", div_cur);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
